jesd204_soft_pcs_rx_sync: RTL and testbench

- Code-group synchronization stage directly downstream of jesd204_pattern_align in the soft-PCS receive path.
- Consumes the aligned 10b symbol stream and runs a per-lane sync FSM: K28.5 comma counting, then invalid-code tracking with error decay.
- Produces lane sync status and registered pass-through data.
- Drives patternalign_en back to the aligner, so alignment is frozen once sync is acquired.

---
 rtl/jesd204_soft_pcs_pkg.sv | 29 ++
 rtl/jesd204_soft_pcs_sync_step.sv | 86 ++++++++
 rtl/jesd204_soft_pcs_rx_sync.sv | 107 ++++++++++
 tb/tb_jesd204_soft_pcs_rx_sync.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/jesd204_soft_pcs_pkg.sv
// Shared constants and types for the JESD204 soft-PCS receive sync stage.
package jesd204_soft_pcs_pkg;

  localparam int unsigned SYM_W      = 10;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned LOSS_CNT_W = 16;

  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0101111100;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1010000011;

  typedef enum logic [1:0] {
    ST_LOSS_OF_SYNC  = 2'd0,
    ST_COMMA_DETECT  = 2'd1,
    ST_SYNC_ACQUIRED = 2'd2,
    ST_SYNC_ERRORED  = 2'd3
  } sync_state_e;

  typedef struct packed {
    sync_state_e      state;
    logic [CNT_W-1:0] comma_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] good_cnt;
  } sync_ctx_t;

  function automatic logic is_comma(input logic [SYM_W-1:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/jesd204_soft_pcs_sync_step.sv
// Single-symbol code-group sync transition: pure combinational next-state/counter function.
module jesd204_soft_pcs_sync_step
  import jesd204_soft_pcs_pkg::*;
#(
  parameter int unsigned COMMA_COUNT = 4,
  parameter int unsigned ERR_LIMIT   = 4,
  parameter int unsigned GOOD_DECAY  = 4
) (
  input  sync_ctx_t        in_ctx,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             in_invalid,
  output sync_ctx_t        out_ctx_c,
  output logic             out_loss_c
);

  logic             comma_ok;
  logic [CNT_W-1:0] comma_inc;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] err_dec;
  logic [CNT_W-1:0] good_inc;

  assign comma_ok  = !in_invalid && is_comma(in_sym);
  assign comma_inc = in_ctx.comma_cnt + CNT_W'(1);
  assign err_inc   = in_ctx.err_cnt + CNT_W'(1);
  assign err_dec   = in_ctx.err_cnt - CNT_W'(1);
  assign good_inc  = in_ctx.good_cnt + CNT_W'(1);

  always_comb begin
    out_ctx_c  = in_ctx;
    out_loss_c = 1'b0;
    case (in_ctx.state)
      ST_LOSS_OF_SYNC: begin
        if (comma_ok) begin
          out_ctx_c.state     = ST_COMMA_DETECT;
          out_ctx_c.comma_cnt = CNT_W'(1);
        end
      end
      ST_COMMA_DETECT: begin
        if (!comma_ok) begin
          out_ctx_c.state     = ST_LOSS_OF_SYNC;
          out_ctx_c.comma_cnt = '0;
        end else if (comma_inc == CNT_W'(COMMA_COUNT)) begin
          out_ctx_c.state     = ST_SYNC_ACQUIRED;
          out_ctx_c.comma_cnt = '0;
          out_ctx_c.err_cnt   = '0;
          out_ctx_c.good_cnt  = '0;
        end else begin
          out_ctx_c.comma_cnt = comma_inc;
        end
      end
      ST_SYNC_ACQUIRED: begin
        if (in_invalid) begin
          out_ctx_c.state    = ST_SYNC_ERRORED;
          out_ctx_c.err_cnt  = CNT_W'(1);
          out_ctx_c.good_cnt = '0;
        end
      end
      ST_SYNC_ERRORED: begin
        if (in_invalid) begin
          out_ctx_c.good_cnt = '0;
          if (err_inc == CNT_W'(ERR_LIMIT)) begin
            out_ctx_c.state     = ST_LOSS_OF_SYNC;
            out_ctx_c.comma_cnt = '0;
            out_ctx_c.err_cnt   = '0;
            out_loss_c          = 1'b1;
          end else begin
            out_ctx_c.err_cnt = err_inc;
          end
        end else if (good_inc == CNT_W'(GOOD_DECAY)) begin
          // A full run of good symbols retires one outstanding error.
          out_ctx_c.good_cnt = '0;
          out_ctx_c.err_cnt  = err_dec;
          if (err_dec == '0) begin
            out_ctx_c.state = ST_SYNC_ACQUIRED;
          end
        end else begin
          out_ctx_c.good_cnt = good_inc;
        end
      end
      default: begin
        out_ctx_c.state = ST_LOSS_OF_SYNC;
      end
    endcase
  end

endmodule

// File: rtl/jesd204_soft_pcs_rx_sync.sv
// Per-lane code-group sync FSM downstream of the pattern aligner.
// Optional loss-of-sync event counter: JESD204_SOFT_PCS_SYNC_STATS_EN.
module jesd204_soft_pcs_rx_sync
  import jesd204_soft_pcs_pkg::*;
#(
  parameter int unsigned DATA_PATH_WIDTH = 4,
  parameter int unsigned COMMA_COUNT     = 4,
  parameter int unsigned ERR_LIMIT       = 4,
  parameter int unsigned GOOD_DECAY      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SYM_W*DATA_PATH_WIDTH-1:0]   in_data,
  input  logic [DATA_PATH_WIDTH-1:0]         in_invalid,
  output logic [SYM_W*DATA_PATH_WIDTH-1:0]   out_data,
  output logic                               out_sync,
  output logic                               patternalign_en,
  output logic [1:0]                         status_state,
  output logic [CNT_W-1:0]                   status_err_cnt,
  output logic [LOSS_CNT_W-1:0]              status_loss_cnt
);

  localparam int unsigned DATA_W = SYM_W * DATA_PATH_WIDTH;

  sync_ctx_t                          ctx_q, ctx_d;
  sync_ctx_t [DATA_PATH_WIDTH:0]      chain_c;
  logic      [DATA_PATH_WIDTH-1:0]    loss_c;
  logic      [DATA_W-1:0]             out_data_q, out_data_d;
  logic                               out_sync_q, out_sync_d;
  logic                               pen_q, pen_d;

  assign chain_c[0] = ctx_q;

  // Symbols are applied in time order, symbol 0 first.
  for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_step
    jesd204_soft_pcs_sync_step #(
      .COMMA_COUNT (COMMA_COUNT),
      .ERR_LIMIT   (ERR_LIMIT),
      .GOOD_DECAY  (GOOD_DECAY)
    ) u_step (
      .in_ctx     (chain_c[i]),
      .in_sym     (in_data[SYM_W*i +: SYM_W]),
      .in_invalid (in_invalid[i]),
      .out_ctx_c  (chain_c[i+1]),
      .out_loss_c (loss_c[i])
    );
  end

  always_comb begin
    ctx_d      = chain_c[DATA_PATH_WIDTH];
    out_data_d = in_data;
    out_sync_d = (ctx_d.state == ST_SYNC_ACQUIRED) || (ctx_d.state == ST_SYNC_ERRORED);
    pen_d      = !out_sync_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctx_q.state     <= ST_LOSS_OF_SYNC;
      ctx_q.comma_cnt <= '0;
      ctx_q.err_cnt   <= '0;
      ctx_q.good_cnt  <= '0;
      out_data_q      <= '0;
      out_sync_q      <= 1'b0;
      pen_q           <= 1'b1;
    end else begin
      ctx_q      <= ctx_d;
      out_data_q <= out_data_d;
      out_sync_q <= out_sync_d;
      pen_q      <= pen_d;
    end
  end

  assign out_data        = out_data_q;
  assign out_sync        = out_sync_q;
  assign patternalign_en = pen_q;
  assign status_state    = ctx_q.state;
  assign status_err_cnt  = ctx_q.err_cnt;

`ifdef JESD204_SOFT_PCS_SYNC_STATS_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [LOSS_CNT_W:0]   loss_sum_c;

  // One extra sum bit detects overflow for saturation.
  always_comb begin
    loss_sum_c = {1'b0, loss_cnt_q};
    for (int i = 0; i < int'(DATA_PATH_WIDTH); i++) begin
      loss_sum_c = loss_sum_c + {LOSS_CNT_W'(0), loss_c[i]};
    end
    loss_cnt_d = loss_sum_c[LOSS_CNT_W] ? '1 : loss_sum_c[LOSS_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign status_loss_cnt = loss_cnt_q;
`else
  logic unused_loss_c;
  assign unused_loss_c   = ^loss_c;
  assign status_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_jesd204_soft_pcs_rx_sync.sv
// Self-checking bench for jesd204_soft_pcs_rx_sync at DATA_PATH_WIDTH 1 and 4.
module tb_jesd204_soft_pcs_rx_sync;

  localparam logic [9:0] K = 10'b0101111100;
  localparam logic [9:0] P = 10'b1010000011;
  localparam logic [9:0] D = 10'b1001110100;
  localparam logic [9:0] X = 10'b0101111000;

`ifdef JESD204_SOFT_PCS_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [39:0] data;
    logic [3:0]  inv;
    logic [1:0]  st;
    logic [2:0]  err;
    logic [15:0] loss;
    string       name;
  } vec_t;

  typedef struct {
    logic [39:0] data;
    logic [1:0]  st;
    logic [2:0]  err;
    logic        sync;
    logic        pen;
    logic [15:0] loss;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1 = 1'b1, rst4 = 1'b1;
  logic [9:0]  d1 = '0;
  logic [0:0]  inv1 = '0;
  logic [39:0] d4 = '0;
  logic [3:0]  inv4 = '0;
  logic [9:0]  od1;
  logic [39:0] od4;
  logic        sync1, sync4, pen1, pen4;
  logic [1:0]  st1, st4;
  logic [2:0]  err1, err4;
  logic [15:0] loss1, loss4;

  jesd204_soft_pcs_rx_sync #(.DATA_PATH_WIDTH(1)) dut1 (
    .clk(clk), .reset(rst1), .in_data(d1), .in_invalid(inv1),
    .out_data(od1), .out_sync(sync1), .patternalign_en(pen1),
    .status_state(st1), .status_err_cnt(err1), .status_loss_cnt(loss1)
  );

  jesd204_soft_pcs_rx_sync #(.DATA_PATH_WIDTH(4)) dut4 (
    .clk(clk), .reset(rst4), .in_data(d4), .in_invalid(inv4),
    .out_data(od4), .out_sync(sync4), .patternalign_en(pen4),
    .status_state(st4), .status_err_cnt(err4), .status_loss_cnt(loss4)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q1[$];
  exp_t q4[$];
  vec_t tab1[$];

  task automatic check(input string name, input string field,
                       input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", name, field, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [39:0] data, input logic [3:0] inv,
                              input logic [1:0] st, input logic [2:0] err,
                              input logic [15:0] loss, input string name);
    vec_t v;
    v.rst = rst; v.data = data; v.inv = inv; v.st = st; v.err = err; v.loss = loss; v.name = name;
    return v;
  endfunction

  task automatic score(input bit wide);
    exp_t e;
    if ((wide ? q4.size() : q1.size()) == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty wide=%0d got=empty want=entry", wide);
      return;
    end
    e = wide ? q4.pop_front() : q1.pop_front();
    if (wide) begin
      check(e.name, "data", 64'(od4), 64'(e.data));
      check(e.name, "state", 64'(st4), 64'(e.st));
      check(e.name, "err", 64'(err4), 64'(e.err));
      check(e.name, "sync", 64'(sync4), 64'(e.sync));
      check(e.name, "pen", 64'(pen4), 64'(e.pen));
      check(e.name, "loss", 64'(loss4), 64'(e.loss));
    end else begin
      check(e.name, "data", 64'(od1), 64'(e.data));
      check(e.name, "state", 64'(st1), 64'(e.st));
      check(e.name, "err", 64'(err1), 64'(e.err));
      check(e.name, "sync", 64'(sync1), 64'(e.sync));
      check(e.name, "pen", 64'(pen1), 64'(e.pen));
      check(e.name, "loss", 64'(loss1), 64'(e.loss));
    end
  endtask

  task automatic apply(input bit wide, input vec_t v);
    exp_t e;
    @(negedge clk);
    if (wide) begin
      rst4 = v.rst; d4 = v.data; inv4 = v.inv;
    end else begin
      rst1 = v.rst; d1 = v.data[9:0]; inv1 = v.inv[0:0];
    end
    e.data = v.rst ? 40'h0 : (wide ? v.data : {30'h0, v.data[9:0]});
    e.st   = v.st;
    e.err  = v.err;
    e.sync = (v.st == 2'd2) || (v.st == 2'd3);
    e.pen  = (v.st == 2'd0) || (v.st == 2'd1);
    e.loss = STATS ? v.loss : 16'h0;
    e.name = v.name;
    if (wide) q4.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1;
    score(wide);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // rst, data, inv, state, err, loss, name
    tab1.push_back(mk(1, 40'(D), 4'd1, 2'd0, 3'd0, 16'd0, "reset"));
    tab1.push_back(mk(0, 40'(X), 4'd0, 2'd0, 3'd0, 16'd0, "partial_comma"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd1, 3'd0, 16'd0, "c1"));
    tab1.push_back(mk(0, 40'(P), 4'd0, 2'd1, 3'd0, 16'd0, "c2_rdp"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd1, 3'd0, 16'd0, "c3"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd0, 3'd0, 16'd0, "noncomma_drop"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd1, 3'd0, 16'd0, "rc1"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd1, 3'd0, 16'd0, "rc2"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd1, 3'd0, 16'd0, "rc3"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd2, 3'd0, 16'd0, "acquire"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd2, 3'd0, 16'd0, "hold_sync"));
    tab1.push_back(mk(0, 40'(D), 4'd1, 2'd3, 3'd1, 16'd0, "err1"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd1, 16'd0, "good1"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd1, 16'd0, "good2"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd3, 3'd1, 16'd0, "good3"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd2, 3'd0, 16'd0, "decay_to_sync"));
    tab1.push_back(mk(0, 40'(D), 4'd1, 2'd3, 3'd1, 16'd0, "s_inv1"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd1, 16'd0, "s_v1a"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd1, 16'd0, "s_v1b"));
    tab1.push_back(mk(0, 40'(D), 4'd1, 2'd3, 3'd2, 16'd0, "s_inv2"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd2, 16'd0, "s_v2a"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd2, 16'd0, "s_v2b"));
    tab1.push_back(mk(0, 40'(D), 4'd1, 2'd3, 3'd3, 16'd0, "s_inv3"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd3, 16'd0, "s_v3a"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd3, 16'd0, "s_v3b"));
    tab1.push_back(mk(0, 40'(D), 4'd1, 2'd0, 3'd0, 16'd1, "s_inv4_loss"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd1, 3'd0, 16'd1, "r_c1"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd1, 3'd0, 16'd1, "r_c2"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd1, 3'd0, 16'd1, "r_c3"));
    tab1.push_back(mk(0, 40'(K), 4'd0, 2'd2, 3'd0, 16'd1, "r_acquire"));
    tab1.push_back(mk(0, 40'(D), 4'd1, 2'd3, 3'd1, 16'd1, "r_err1"));
    tab1.push_back(mk(0, 40'(D), 4'd0, 2'd3, 3'd1, 16'd1, "r_good"));
    tab1.push_back(mk(0, 40'(D), 4'd1, 2'd3, 3'd2, 16'd1, "r_err2"));
    tab1.push_back(mk(1, 40'(K), 4'd1, 2'd0, 3'd0, 16'd0, "reset_mid"));

    for (int i = 0; i < tab1.size(); i++) begin
      apply(1'b0, tab1[i]);
    end

    // Wide lane: symbol 0 sits in bits [9:0] and is earliest.
    apply(1'b1, mk(1, {D, D, D, D}, 4'b1111, 2'd0, 3'd0, 16'd0, "w4_reset"));
    apply(1'b1, mk(0, {P, K, P, K}, 4'b0000, 2'd2, 3'd0, 16'd0, "w4_acquire"));
    apply(1'b1, mk(0, {D, D, D, D}, 4'b0111, 2'd3, 3'd3, 16'd0, "w4_err3"));
    apply(1'b1, mk(0, {K, K, K, D}, 4'b0001, 2'd1, 3'd0, 16'd1, "w4_loss_recomma"));
    apply(1'b1, mk(0, {D, D, D, K}, 4'b0000, 2'd2, 3'd0, 16'd1, "w4_reacquire"));
    apply(1'b1, mk(0, {D, D, D, D}, 4'b1111, 2'd0, 3'd0, 16'd2, "w4_all_invalid"));
    apply(1'b1, mk(0, {D, X, D, D}, 4'b0000, 2'd0, 3'd0, 16'd2, "w4_stay_loss"));
    apply(1'b1, mk(1, {K, K, K, K}, 4'b0000, 2'd0, 3'd0, 16'd0, "w4_reset_mid"));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
